// File: rtl/demux_stream_pkg.sv
// Shared types and helpers for the packet-aware stream demultiplexer.
package demux_stream_pkg;

  // Packet-level steering state: waiting for a packet head, routing the
  // body of a locked packet, or discarding the body of a rejected packet.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  // Width of the dropped-packet counter.
  localparam int DROP_CNT_W = 8;

  // Select width for n channels, never narrower than one bit.
  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_hold_slot.sv
// Single-entry registered holding slot carrying {dest, last, data}.
// A new beat may be loaded in the same cycle the current one drains, so a
// continuously ready consumer sees one beat per clock.
module demux_hold_slot
  import demux_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEST_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DEST_W-1:0] load_dest,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              in_ready,
  output logic              hold_valid,
  output logic [DEST_W-1:0] hold_dest,
  output logic              hold_last,
  output logic [DATA_W-1:0] hold_data
);

  logic drain;

  // The slot empties when its current destination lane takes the beat.
  assign drain    = hold_valid && out_ready;
  // Room for a new beat: empty now, or emptying at this edge.
  assign in_ready = !hold_valid || out_ready;

  // Slot register: load has priority so drain+refill keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_dest  <= '0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (load) begin
        hold_valid <= 1'b1;
        hold_dest  <= load_dest;
        hold_last  <= load_last;
        hold_data  <= load_data;
      end else if (drain) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_stream.sv
// Packet-aware 1:N valid/ready stream demultiplexer.
// The destination is taken from the first beat of each packet and locked
// for the rest of it; beats are steered through one registered slot to the
// selected lane. Packets whose select is out of range are swallowed whole
// and counted in a saturating drop counter.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter  int N_OUT  = 2,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = sel_w(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_last,
  output logic [N_OUT-1:0]        m_valid,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic [N_OUT-1:0]        m_last,
  output logic [DROP_CNT_W-1:0]   drop_cnt,
  output logic                    busy
);

  // Exclusive upper bound on a legal select, one bit wider than the select.
  localparam logic [SEL_W:0] SEL_LIM = (SEL_W + 1)'(N_OUT);

  state_t             state;
  logic [SEL_W-1:0]   lock_dest;

  logic               s_accept;
  logic               sel_ok;
  logic               slot_load;
  logic [SEL_W-1:0]   slot_dest;
  logic               slot_in_ready;
  logic               lane_accept;

  logic               hold_valid;
  logic [SEL_W-1:0]   hold_dest;
  logic               hold_last;
  logic [DATA_W-1:0]  hold_data;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction

  assign sel_ok   = ({1'b0, s_sel} < SEL_LIM);
  assign s_accept = s_valid && s_ready;

  // Discarded beats never touch the slot, so DROP can always take input.
  // Elsewhere the slot decides; s_valid never feeds back into s_ready.
  assign s_ready = (state == DROP) ? 1'b1 : slot_in_ready;

  // Heads load only with a legal select; bodies load only while routing.
  assign slot_load = s_accept && (((state == IDLE) && sel_ok) || (state == ROUTE));
  assign slot_dest = (state == ROUTE) ? lock_dest : s_sel;

  // At most one lane is valid, so any lane handshake is the slot draining.
  assign lane_accept = |(m_valid & m_ready);

  demux_hold_slot #(
    .DATA_W (DATA_W),
    .DEST_W (SEL_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (slot_load),
    .load_dest  (slot_dest),
    .load_last  (s_last),
    .load_data  (s_data),
    .out_ready  (lane_accept),
    .in_ready   (slot_in_ready),
    .hold_valid (hold_valid),
    .hold_dest  (hold_dest),
    .hold_last  (hold_last),
    .hold_data  (hold_data)
  );

  // Lane decode: raise only the valid of the lane the slot is addressed to.
  always_comb begin
    m_valid = '0;
    for (int k = 0; k < N_OUT; k++) begin
      m_valid[k] = hold_valid && (hold_dest == SEL_W'(k));
    end
  end

  assign m_last = m_valid & {N_OUT{hold_last}};
  assign m_data = {N_OUT{hold_data}};
  assign busy   = (state != IDLE) || hold_valid;

  // Packet FSM: lock the destination or start a drop on each packet head,
  // and return to IDLE on the accepted last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lock_dest <= '0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_accept) begin
            if (sel_ok) begin
              lock_dest <= s_sel;
              if (!s_last) state <= ROUTE;
            end else begin
              drop_cnt <= sat_inc(drop_cnt);
              if (!s_last) state <= DROP;
            end
          end
        end
        ROUTE, DROP: begin
          if (s_accept && s_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: a 2-lane instance (a_*) and a 3-lane instance
// (b_*) whose out-of-range select exercises packet dropping.
module tb_demux_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int tests  = 0;
  int failed = 0;

  logic        a_s_valid, a_s_ready, a_s_last, a_busy;
  logic [7:0]  a_s_data, a_drop_cnt;
  logic [0:0]  a_s_sel;
  logic [1:0]  a_m_valid, a_m_ready, a_m_last;
  logic [15:0] a_m_data;

  logic        b_s_valid, b_s_ready, b_s_last, b_busy;
  logic [7:0]  b_s_data, b_drop_cnt;
  logic [1:0]  b_s_sel;
  logic [2:0]  b_m_valid, b_m_ready, b_m_last;
  logic [23:0] b_m_data;

  // Reference model: expected beats in global order (single slot keeps order)
  int a_exp[$], a_obs[$], b_exp[$], b_obs[$];
  int b_drop_model = 0;

  demux_stream #(.N_OUT(2), .DATA_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_sel(a_s_sel), .s_last(a_s_last),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last),
    .drop_cnt(a_drop_cnt), .busy(a_busy)
  );

  demux_stream #(.N_OUT(3), .DATA_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_sel(b_s_sel), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .drop_cnt(b_drop_cnt), .busy(b_busy)
  );

  function automatic int enc(input int lane, input logic last, input logic [7:0] d);
    return (lane << 9) | (int'(last) << 8) | int'(d);
  endfunction

  // Monitors: record lane handshakes, check slot hold and upstream stability
  logic [1:0]  a_pv, a_pr, a_pl;  logic [15:0] a_pd;  logic a_armed = 1'b0;
  logic [2:0]  b_pv, b_pr, b_pl;  logic [23:0] b_pd;  logic b_armed = 1'b0;
  logic        a_pend = 1'b0, b_pend = 1'b0;
  logic [7:0]  a_pend_d, b_pend_d;  logic a_pend_l, b_pend_l;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++)
        if (a_m_valid[k] && a_m_ready[k]) a_obs.push_back(enc(k, a_m_last[k], a_m_data[k*8 +: 8]));
      if (a_armed && ((a_pv & ~a_pr) != 2'b00)) begin
        tests++;
        if (a_m_valid !== a_pv || a_m_data !== a_pd || a_m_last !== a_pl) begin
          failed++;
          $display("FAIL a_slot_hold: valid=%b data=%h last=%b, required valid=%b data=%h last=%b",
                   a_m_valid, a_m_data, a_m_last, a_pv, a_pd, a_pl);
        end
      end
      if (a_pend) begin
        tests++;
        if (a_s_valid !== 1'b1 || a_s_data !== a_pend_d || a_s_last !== a_pend_l) begin
          failed++;
          $display("FAIL a_upstream_stable: valid=%b data=%h, required 1 %h", a_s_valid, a_s_data, a_pend_d);
        end
      end
    end
    a_pv = a_m_valid; a_pr = a_m_ready; a_pd = a_m_data; a_pl = a_m_last; a_armed = rst_n;
    a_pend = rst_n && a_s_valid && !a_s_ready; a_pend_d = a_s_data; a_pend_l = a_s_last;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++)
        if (b_m_valid[k] && b_m_ready[k]) b_obs.push_back(enc(k, b_m_last[k], b_m_data[k*8 +: 8]));
      if (b_armed && ((b_pv & ~b_pr) != 3'b000)) begin
        tests++;
        if (b_m_valid !== b_pv || b_m_data !== b_pd || b_m_last !== b_pl) begin
          failed++;
          $display("FAIL b_slot_hold: valid=%b data=%h last=%b, required valid=%b data=%h last=%b",
                   b_m_valid, b_m_data, b_m_last, b_pv, b_pd, b_pl);
        end
      end
      if (b_pend) begin
        tests++;
        if (b_s_valid !== 1'b1 || b_s_data !== b_pend_d || b_s_last !== b_pend_l) begin
          failed++;
          $display("FAIL b_upstream_stable: valid=%b data=%h, required 1 %h", b_s_valid, b_s_data, b_pend_d);
        end
      end
    end
    b_pv = b_m_valid; b_pr = b_m_ready; b_pd = b_m_data; b_pl = b_m_last; b_armed = rst_n;
    b_pend = rst_n && b_s_valid && !b_s_ready; b_pend_d = b_s_data; b_pend_l = b_s_last;
  end

  // Drivers: called at posedge+1, return at posedge+1 after the accepting edge
  task automatic a_send(input logic [7:0] d, input logic sel, input logic last,
                        input int exp_lane, output int waits);
    logic acc;
    if (exp_lane >= 0) a_exp.push_back(enc(exp_lane, last, d));
    a_s_valid = 1'b1; a_s_data = d; a_s_sel = sel; a_s_last = last;
    waits = 0; acc = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk); acc = a_s_ready; waits++;
      @(posedge clk); #1;
    end
    a_s_valid = 1'b0;
    tests++;
    if (!acc) begin
      failed++;
      $display("FAIL a_accept_timeout: s_ready=%b after %0d cycles, required 1", a_s_ready, waits);
    end
  endtask

  task automatic b_send(input logic [7:0] d, input logic [1:0] sel, input logic last,
                        input int exp_lane, output int waits);
    logic acc;
    if (exp_lane >= 0) b_exp.push_back(enc(exp_lane, last, d));
    b_s_valid = 1'b1; b_s_data = d; b_s_sel = sel; b_s_last = last;
    waits = 0; acc = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk); acc = b_s_ready; waits++;
      @(posedge clk); #1;
    end
    b_s_valid = 1'b0;
    tests++;
    if (!acc) begin
      failed++;
      $display("FAIL b_accept_timeout: s_ready=%b after %0d cycles, required 1", b_s_ready, waits);
    end
  endtask

  task automatic a_check_stream(input string name);
    int n = 0;
    a_m_ready = 2'b11;
    while (a_busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    tests++;
    if (n >= 200) begin failed++; $display("FAIL %s_drain: busy=%b, required 0", name, a_busy); end
    tests++;
    if (a_obs.size() != a_exp.size()) begin
      failed++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, a_obs.size(), a_exp.size());
    end else begin
      for (int i = 0; i < a_exp.size(); i++) begin
        tests++;
        if (a_obs[i] != a_exp[i]) begin
          failed++;
          $display("FAIL %s_beat%0d: got lane=%0d last=%0d data=%02h, required lane=%0d last=%0d data=%02h",
                   name, i, a_obs[i] >> 9, (a_obs[i] >> 8) & 1, a_obs[i] & 255,
                   a_exp[i] >> 9, (a_exp[i] >> 8) & 1, a_exp[i] & 255);
        end
      end
    end
    a_obs.delete(); a_exp.delete();
  endtask

  task automatic b_check_stream(input string name);
    int n = 0;
    b_m_ready = 3'b111;
    while (b_busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    tests++;
    if (n >= 200) begin failed++; $display("FAIL %s_drain: busy=%b, required 0", name, b_busy); end
    tests++;
    if (b_obs.size() != b_exp.size()) begin
      failed++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, b_obs.size(), b_exp.size());
    end else begin
      for (int i = 0; i < b_exp.size(); i++) begin
        tests++;
        if (b_obs[i] != b_exp[i]) begin
          failed++;
          $display("FAIL %s_beat%0d: got lane=%0d last=%0d data=%02h, required lane=%0d last=%0d data=%02h",
                   name, i, b_obs[i] >> 9, (b_obs[i] >> 8) & 1, b_obs[i] & 255,
                   b_exp[i] >> 9, (b_exp[i] >> 8) & 1, b_exp[i] & 255);
        end
      end
    end
    tests++;
    if (b_drop_cnt !== 8'(b_drop_model)) begin
      failed++;
      $display("FAIL %s_drop_cnt: got %0d, required %0d", name, b_drop_cnt, b_drop_model);
    end
    b_obs.delete(); b_exp.delete();
  endtask

  task automatic test_reset();
    tests++;
    if (a_m_valid !== 2'b00 || a_m_last !== 2'b00 || a_m_data !== 16'h0) begin
      failed++; $display("FAIL reset_a_outputs: valid=%b last=%b data=%h, required 0", a_m_valid, a_m_last, a_m_data);
    end
    tests++;
    if (a_busy !== 1'b0 || a_drop_cnt !== 8'd0 || a_s_ready !== 1'b1) begin
      failed++; $display("FAIL reset_a_ctrl: busy=%b drop=%0d s_ready=%b, required 0 0 1", a_busy, a_drop_cnt, a_s_ready);
    end
    tests++;
    if (b_m_valid !== 3'b000 || b_m_last !== 3'b000 || b_m_data !== 24'h0 || b_busy !== 1'b0 || b_drop_cnt !== 8'd0) begin
      failed++; $display("FAIL reset_b: valid=%b data=%h busy=%b drop=%0d, required all 0", b_m_valid, b_m_data, b_busy, b_drop_cnt);
    end
  endtask

  task automatic test_single_beat();
    int w;
    a_m_ready = 2'b11;
    a_send(8'hA5, 1'b1, 1'b1, 1, w);
    tests++;
    if (a_m_valid !== 2'b10 || a_m_data[15:8] !== 8'hA5 || a_m_last !== 2'b10) begin
      failed++; $display("FAIL single_beat: valid=%b lane1=%h last=%b, required 10 a5 10", a_m_valid, a_m_data[15:8], a_m_last);
    end
    tests++;
    if (a_drop_cnt !== 8'd0) begin failed++; $display("FAIL single_drop: got %0d, required 0", a_drop_cnt); end
    a_check_stream("single");
  endtask

  task automatic test_three_beat();
    int w;
    a_m_ready = 2'b11;
    a_send(8'h01, 1'b0, 1'b0, 0, w);
    a_send(8'h02, 1'b1, 1'b0, 0, w);
    a_send(8'h03, 1'b1, 1'b1, 0, w);
    tests++;
    if (a_m_valid !== 2'b01 || a_m_last !== 2'b01) begin
      failed++; $display("FAIL three_beat_lock: valid=%b last=%b, required 01 01", a_m_valid, a_m_last);
    end
    a_check_stream("three_beat");
    tests++;
    if (a_busy !== 1'b0) begin failed++; $display("FAIL three_beat_idle: busy=%b, required 0", a_busy); end
  endtask

  task automatic test_backpressure();
    int w;
    logic [7:0] d[6];
    for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
    a_m_ready = 2'b11;
    a_send(d[0], 1'b0, 1'b0, 0, w);
    a_send(d[1], 1'b0, 1'b0, 0, w);
    a_m_ready = 2'b10;
    a_s_valid = 1'b1; a_s_data = d[2]; a_s_sel = 1'b1; a_s_last = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (a_s_ready !== 1'b0) begin failed++; $display("FAIL bp_s_ready c%0d: got %b, required 0", c, a_s_ready); end
      tests++;
      if (a_m_valid !== 2'b01 || a_m_data[7:0] !== d[1]) begin
        failed++; $display("FAIL bp_hold c%0d: valid=%b data=%h, required 01 %h", c, a_m_valid, a_m_data[7:0], d[1]);
      end
      @(posedge clk); #1;
    end
    a_m_ready = 2'b11;
    for (int i = 2; i < 6; i++) begin
      a_send(d[i], 1'b1, (i == 5), 0, w);
      tests++;
      if (w != 1) begin failed++; $display("FAIL bp_resume_rate beat%0d: took %0d cycles, required 1", i, w); end
    end
    a_check_stream("backpressure");
  endtask

  task automatic test_back_to_back();
    int w;
    logic [7:0] dv[3] = '{8'h10, 8'h11, 8'h20};
    logic       sv[3] = '{1'b0, 1'b1, 1'b1};
    logic       lv[3] = '{1'b0, 1'b1, 1'b1};
    int         ln[3] = '{0, 0, 1};
    logic [1:0] mv[3] = '{2'b01, 2'b01, 2'b10};
    a_m_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      a_send(dv[i], sv[i], lv[i], ln[i], w);
      tests++;
      if (w != 1 || a_m_valid !== mv[i]) begin
        failed++; $display("FAIL b2b beat%0d: cycles=%0d valid=%b, required 1 %b", i, w, a_m_valid, mv[i]);
      end
    end
    a_check_stream("back_to_back");
  endtask

  task automatic test_random_a();
    bit done = 0;
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          int len = $urandom_range(1, 4);
          int s0  = $urandom_range(0, 1);
          int w;
          for (int b = 0; b < len; b++) begin
            logic sel = (b == 0) ? 1'(s0) : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            a_send(8'($urandom), sel, (b == len - 1), s0, w);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          a_m_ready = 2'($urandom_range(0, 3));
        end
      end
    join
    a_check_stream("random_a");
  endtask

  task automatic test_drop();
    int w;
    b_m_ready = 3'b111;
    b_send(8'h11, 2'd3, 1'b0, -1, w);
    b_drop_model = 1;
    tests++;
    if (w != 1 || b_drop_cnt !== 8'd1 || b_m_valid !== 3'b000) begin
      failed++; $display("FAIL drop_head: cycles=%0d drop=%0d valid=%b, required 1 1 000", w, b_drop_cnt, b_m_valid);
    end
    b_send(8'h12, 2'd0, 1'b1, -1, w);
    tests++;
    if (w != 1 || b_drop_cnt !== 8'd1 || b_m_valid !== 3'b000 || b_busy !== 1'b0) begin
      failed++; $display("FAIL drop_tail: cycles=%0d drop=%0d valid=%b busy=%b, required 1 1 000 0", w, b_drop_cnt, b_m_valid, b_busy);
    end
    b_send(8'h33, 2'd2, 1'b1, 2, w);
    tests++;
    if (b_m_valid !== 3'b100 || b_m_data[23:16] !== 8'h33) begin
      failed++; $display("FAIL drop_recover: valid=%b lane2=%h, required 100 33", b_m_valid, b_m_data[23:16]);
    end
    b_check_stream("drop");
  endtask

  task automatic test_random_b();
    bit done = 0;
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          int len = $urandom_range(1, 3);
          int s0  = $urandom_range(0, 3);
          int w;
          if (s0 == 3 && b_drop_model < 255) b_drop_model++;
          for (int b = 0; b < len; b++) begin
            logic [1:0] sel = (b == 0) ? 2'(s0) : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            b_send(8'($urandom), sel, (b == len - 1), (s0 == 3) ? -1 : s0, w);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          b_m_ready = 3'($urandom_range(0, 7));
        end
      end
    join
    b_check_stream("random_b");
  endtask

  task automatic test_drop_saturate();
    int w;
    b_m_ready = 3'b111;
    for (int i = 0; i < 256; i++) begin
      b_send(8'($urandom), 2'd3, 1'b1, -1, w);
      if (b_drop_model < 255) b_drop_model++;
    end
    b_check_stream("drop_saturate");
    tests++;
    if (b_drop_cnt !== 8'd255) begin failed++; $display("FAIL drop_sat: got %0d, required 255", b_drop_cnt); end
  endtask

  task automatic test_reset_mid();
    int w;
    a_m_ready = 2'b00;
    a_send(8'h77, 1'b0, 1'b0, -1, w);
    tests++;
    if (a_m_valid !== 2'b01 || a_busy !== 1'b1) begin
      failed++; $display("FAIL rstmid_pre: valid=%b busy=%b, required 01 1", a_m_valid, a_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (a_m_valid !== 2'b00 || a_busy !== 1'b0 || a_m_data !== 16'h0) begin
      failed++; $display("FAIL rstmid_async: valid=%b busy=%b data=%h, required 00 0 0", a_m_valid, a_busy, a_m_data);
    end
    tests++;
    if (b_drop_cnt !== 8'd0) begin failed++; $display("FAIL rstmid_drop_clear: got %0d, required 0", b_drop_cnt); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    a_m_ready = 2'b11;
    a_send(8'h5A, 1'b1, 1'b1, 1, w);
    tests++;
    if (a_m_valid !== 2'b10 || a_m_data[15:8] !== 8'h5A) begin
      failed++; $display("FAIL rstmid_new_pkt: valid=%b lane1=%h, required 10 5a", a_m_valid, a_m_data[15:8]);
    end
    a_check_stream("reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_s_valid = 1'b0; a_s_data = '0; a_s_sel = '0; a_s_last = 1'b0; a_m_ready = '0;
    b_s_valid = 1'b0; b_s_data = '0; b_s_sel = '0; b_s_last = 1'b0; b_m_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_single_beat();
    test_three_beat();
    test_backpressure();
    test_back_to_back();
    test_random_a();
    test_drop();
    test_random_b();
    test_drop_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
